det_window_counter: RTL and testbench

Downstream consumer of the serial pattern detector's single-cycle detect pulse. Counts detect pulses over fixed windows of WINDOW_LEN cycles. Pushes each window's count into a small FIFO, drained over a valid/ready interface by the host/report logic. Gives software a rate measurement instead of raw pulses, with explicit loss reporting under backpressure.

---
 rtl/det_window_counter.sv | 130 +++++++++++++
 tb/tb_det_window_counter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/det_window_counter.sv
// rtl/det_window_counter.sv - counts detect pulses per fixed window and queues per-window counts in a report FIFO
// Optional feature: define DWC_TIMESTAMP_EN to add a window index (idx_o) stored with each report.
module det_window_counter #(
  parameter int WINDOW_LEN = 64,
  parameter int CNT_W      = 8,
  parameter int FIFO_DEPTH = 4
`ifdef DWC_TIMESTAMP_EN
  ,
  parameter int IDX_W      = 16
`endif
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               det_i,
  input  logic                               en_i,
  output logic [CNT_W-1:0]                   cnt_o,
  output logic                               cnt_valid_o,
  input  logic                               cnt_ready_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    level_o,
`ifdef DWC_TIMESTAMP_EN
  output logic [IDX_W-1:0]                   idx_o,
`endif
  output logic                               drop_o
);

  localparam int WIN_W = $clog2(WINDOW_LEN);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PW    = AW + 1;
  localparam int LW    = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] det_cnt;
  logic [CNT_W-1:0] det_next;
  logic             win_end;

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    level;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push_ok;
  logic             pop;
  logic [CNT_W-1:0] cnt_mem [FIFO_DEPTH];

`ifdef DWC_TIMESTAMP_EN
  logic [IDX_W-1:0] idx_cnt;
  logic [IDX_W-1:0] idx_mem [FIFO_DEPTH];
`endif

  // Saturating count including this cycle's pulse; also the report value at window end.
  assign det_next = (det_i && (det_cnt != {CNT_W{1'b1}})) ? det_cnt + CNT_W'(1) : det_cnt;

  // The first enabled cycle out of IDLE is window cycle 0 (win_cnt is 0 there), so it never ends a window.
  assign win_end = en_i && (state == RUN) && (win_cnt == WIN_W'(WINDOW_LEN - 1));

  assign level      = wr_ptr - rd_ptr;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (level == PW'(FIFO_DEPTH));
  assign pop        = !fifo_empty && cnt_ready_i;
  // A full FIFO still takes the report if the head leaves in the same cycle.
  assign push_ok    = win_end && (!fifo_full || pop);

  // Window FSM: dropping en_i abandons the partial window without reporting it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      win_cnt <= '0;
      det_cnt <= '0;
    end else if (!en_i) begin
      state   <= IDLE;
      win_cnt <= '0;
      det_cnt <= '0;
    end else if (win_end) begin
      state   <= RUN;
      win_cnt <= '0;
      det_cnt <= '0;
    end else begin
      state   <= RUN;
      win_cnt <= win_cnt + WIN_W'(1);
      det_cnt <= det_next;
    end
  end

  // FIFO pointers and the sticky loss flag; the extra pointer bit separates full from empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      drop_o <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      if (win_end && !push_ok) drop_o <= 1'b1;
    end
  end

  // Report storage; contents need no reset since the outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      cnt_mem[wr_ptr[AW-1:0]] <= det_next;
`ifdef DWC_TIMESTAMP_EN
      idx_mem[wr_ptr[AW-1:0]] <= idx_cnt;
`endif
    end
  end

`ifdef DWC_TIMESTAMP_EN
  // Window index advances on every window end, dropped or not, so gaps expose loss.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_cnt <= '0;
    end else if (win_end) begin
      idx_cnt <= idx_cnt + IDX_W'(1);
    end
  end

  assign idx_o = fifo_empty ? '0 : idx_mem[rd_ptr[AW-1:0]];
`endif

  assign cnt_o       = fifo_empty ? '0 : cnt_mem[rd_ptr[AW-1:0]];
  assign cnt_valid_o = !fifo_empty;
  assign level_o     = LW'(level);

endmodule

// File: tb/tb_det_window_counter.sv
// tb/tb_det_window_counter.sv - directed self-checking bench for det_window_counter (WINDOW_LEN=8, CNT_W=2, FIFO_DEPTH=4)
module tb_det_window_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic        det_i;
  logic        en_i;
  logic        cnt_ready_i;
  logic [1:0]  cnt_o;
  logic        cnt_valid_o;
  logic [2:0]  level_o;
  logic        drop_o;
`ifdef DWC_TIMESTAMP_EN
  logic [15:0] idx_o;
`endif

  int n_vec = 0;
  int n_err = 0;

  int exp_b[4]     = '{1, 2, 3, 0};
  int exp_b_idx[4] = '{3, 4, 5, 6};
  int exp_c[4]     = '{2, 3, 0, 2};
  int exp_c_idx[4] = '{1, 2, 3, 4};

  det_window_counter #(
    .WINDOW_LEN (8),
    .CNT_W      (2),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .det_i       (det_i),
    .en_i        (en_i),
    .cnt_o       (cnt_o),
    .cnt_valid_o (cnt_valid_o),
    .cnt_ready_i (cnt_ready_i),
    .level_o     (level_o),
`ifdef DWC_TIMESTAMP_EN
    .idx_o       (idx_o),
`endif
    .drop_o      (drop_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input logic det, input logic en, input logic rdy);
    det_i       = det;
    en_i        = en;
    cnt_ready_i = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic run_cycles(input int n, input logic [7:0] pat, input int start, input logic rdy);
    for (int k = start; k < start + n; k++) tick(pat[3'(k)], 1'b1, rdy);
  endtask

  initial begin
    reset = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check_vec("rst_level", level_o, 0);
    check_vec("rst_valid", cnt_valid_o, 0);
    check_vec("rst_cnt", cnt_o, 0);
    check_vec("rst_drop", drop_o, 0);
    reset = 1'b0;

    // A: pulses at 1,4,7 -> 3; report lives one cycle with ready high
    run_cycles(8, 8'b1001_0010, 0, 1'b1);
    check_vec("a_cnt", cnt_o, 3);
    check_vec("a_valid", cnt_valid_o, 1);
    check_vec("a_level1", level_o, 1);
    run_cycles(1, 8'hFF, 0, 1'b1);
    check_vec("a_valid_after_pop", cnt_valid_o, 0);
    check_vec("a_level0", level_o, 0);
    check_vec("a_cnt_empty", cnt_o, 0);
    run_cycles(7, 8'hFF, 1, 1'b1);
    check_vec("sat_cnt", cnt_o, 3);
    check_vec("sat_level", level_o, 1);
    run_cycles(8, 8'h00, 0, 1'b1);
    check_vec("zero_cnt", cnt_o, 0);
    check_vec("zero_valid", cnt_valid_o, 1);
`ifdef DWC_TIMESTAMP_EN
    check_vec("zero_idx", idx_o, 2);
`endif
    tick(1'b0, 1'b0, 1'b1);
    check_vec("a_drained", level_o, 0);

    // B: five windows with no consumer -> full, fifth lost
    run_cycles(8, 8'h01, 0, 1'b0);
    run_cycles(8, 8'h03, 0, 1'b0);
    run_cycles(8, 8'h07, 0, 1'b0);
    run_cycles(8, 8'h00, 0, 1'b0);
    check_vec("b_level_full", level_o, 4);
    check_vec("b_drop_before", drop_o, 0);
    run_cycles(8, 8'h01, 0, 1'b0);
    check_vec("b_level_after_drop", level_o, 4);
    check_vec("b_drop", drop_o, 1);
    tick(1'b0, 1'b0, 1'b0);
    check_vec("b_head_stable", cnt_o, 1);
    check_vec("b_level_stable", level_o, 4);
    for (int i = 0; i < 4; i++) begin
      check_vec($sformatf("b_drain%0d", i), cnt_o, exp_b[i]);
`ifdef DWC_TIMESTAMP_EN
      check_vec($sformatf("b_idx%0d", i), idx_o, exp_b_idx[i]);
`endif
      tick(1'b0, 1'b0, 1'b1);
    end
    check_vec("b_empty_level", level_o, 0);
    check_vec("b_empty_valid", cnt_valid_o, 0);
    check_vec("b_drop_sticky", drop_o, 1);
    run_cycles(8, 8'h03, 0, 1'b0);
    check_vec("b_next_cnt", cnt_o, 2);
`ifdef DWC_TIMESTAMP_EN
    check_vec("b_idx_gap", idx_o, 8);
`endif
    tick(1'b0, 1'b0, 1'b1);

    // D: reset with three entries queued, mid-window
    run_cycles(8, 8'h01, 0, 1'b0);
    run_cycles(8, 8'h03, 0, 1'b0);
    run_cycles(8, 8'h07, 0, 1'b0);
    run_cycles(4, 8'hFF, 0, 1'b0);
    check_vec("d_level_pre", level_o, 3);
    reset = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    check_vec("d_level", level_o, 0);
    check_vec("d_valid", cnt_valid_o, 0);
    check_vec("d_cnt", cnt_o, 0);
    check_vec("d_drop", drop_o, 0);
    reset = 1'b0;

    // C: full FIFO, consumer pops exactly on the window-end cycle
    run_cycles(8, 8'h01, 0, 1'b0);
    run_cycles(8, 8'h03, 0, 1'b0);
    run_cycles(8, 8'h07, 0, 1'b0);
    run_cycles(8, 8'h00, 0, 1'b0);
    check_vec("c_level_full", level_o, 4);
`ifdef DWC_TIMESTAMP_EN
    check_vec("c_idx_first", idx_o, 0);
`endif
    run_cycles(7, 8'h11, 0, 1'b0);
    run_cycles(1, 8'h11, 7, 1'b1);
    check_vec("c_level", level_o, 4);
    check_vec("c_drop", drop_o, 0);
    for (int i = 0; i < 4; i++) begin
      check_vec($sformatf("c_drain%0d", i), cnt_o, exp_c[i]);
`ifdef DWC_TIMESTAMP_EN
      check_vec($sformatf("c_idx%0d", i), idx_o, exp_c_idx[i]);
`endif
      tick(1'b0, 1'b0, 1'b1);
    end
    check_vec("c_empty", level_o, 0);

    // E: enable dropped at window cycle 5 with two pulses counted, re-raised 3 cycles later
    run_cycles(5, 8'b0000_1010, 0, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    run_cycles(7, 8'h81, 0, 1'b0);
    check_vec("e_no_partial_level", level_o, 0);
    check_vec("e_no_partial_valid", cnt_valid_o, 0);
    run_cycles(1, 8'h81, 7, 1'b0);
    check_vec("e_level", level_o, 1);
    check_vec("e_cnt", cnt_o, 2);
`ifdef DWC_TIMESTAMP_EN
    check_vec("e_idx", idx_o, 5);
`endif
    tick(1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
